// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory port: one request at a time against
// word-organised storage, with the response presented a fixed number of edges after accept.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_we,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  req_err;
  logic                  accept;
  logic [31:0]           rd_word;
  logic [31:0]           ld_data;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;
  logic [31:0]           mem [DEPTH_WORDS];

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; rsp_rdata/rsp_err stay put while rsp_valid waits for rsp_ready.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign dbg_state = state;
  assign accept    = req_valid && (state == ST_IDLE);

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign rd_word  = mem[mem_idx];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, word_idx} >= DEPTH_W) req_err = 1'b1;
  end

  // Loads are right-justified and zero-extended; lanes are little-endian.
  always_comb begin
    ld_data = 32'd0;
    case (req_size)
      2'b00:   ld_data = {24'd0, rd_word[{req_addr[1:0], 3'b000} +: 8]};
      2'b01:   ld_data = {16'd0, rd_word[{req_addr[1], 4'b0000} +: 16]};
      2'b10:   ld_data = rd_word;
      default: ld_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_data = req_wdata;
    wr_be   = 4'b0000;
    case (req_size)
      2'b00: begin
        wr_data = {4{req_wdata[7:0]}};
        wr_be   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wr_data = {2{req_wdata[15:0]}};
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_data = req_wdata;
        wr_be   = 4'b1111;
      end
      default: begin
        wr_data = req_wdata;
        wr_be   = 4'b0000;
      end
    endcase
  end

  // Storage has no reset so its contents survive a mid-operation reset.
  always_ff @(posedge CLK) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || req_we) ? 32'd0 : ld_data;
            if (LATENCY <= 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests checked against a byte-array
// model every cycle, plus literal expectations and a LATENCY=1 instance.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        CLK, RST;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size, dbg_state;

  logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [1:0]  req_size1, dbg_state1;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  data_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_size(req_size1), .req_we(req_we1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .dbg_state(dbg_state1)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, required finish before 400us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [7:0]  bm [0:4*DEPTH-1];
  logic [32:0] exp_q[$];
  bit          busy = 1'b0;
  int unsigned cyc = 0, acc_cyc = 0;
  int          nb;
  bit          m_err;
  logic [31:0] m_data;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (busy) begin
        if (cyc >= acc_cyc + LAT && rsp_ready) begin
          busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (req_valid) begin
        nb     = 1 << req_size;
        m_err  = (req_size == 2'b11) || (req_addr % nb != 0) || (req_addr / 4 >= DEPTH);
        m_data = 32'd0;
        if (!m_err) begin
          for (int i = 0; i < nb; i++) begin
            if (req_we) bm[req_addr + i] = req_wdata[8*i +: 8];
            else        m_data = m_data | (32'(bm[req_addr + i]) << (8*i));
          end
        end
        exp_q.push_back({m_err, m_data});
        busy    = 1'b1;
        acc_cyc = cyc;
      end
    end
  end

  always @(negedge CLK) begin
    chk("rsp_valid", rsp_valid, busy && (cyc + 1 >= acc_cyc + LAT));
    chk("req_ready", req_ready, !busy);
    if (busy && (cyc + 1 >= acc_cyc + LAT) && exp_q.size() > 0) begin
      chk("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
      chk("rsp_err", rsp_err, exp_q[0][32]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no rsp_valid, required rsp_valid within 50 cycles", name);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout: got req_ready=0, required 1 within 50 cycles");
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge CLK);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got no rsp_valid, required rsp_valid within 50 cycles");
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge CLK);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;
  int          lat;

  logic [31:0] l1_addr [8] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h104, 32'h100, 32'h10C, 32'h108};
  logic        l1_we   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] l1_wd   [8] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 0, 0, 0, 0};
  logic [31:0] l1_exp  [8] = '{0, 0, 0, 0, 32'hB2B2B2B2, 32'hA1A1A1A1, 32'hD4D4D4D4, 32'hC3C3C3C3};

  initial begin
    RST = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_addr = 0; req_wdata = 0;
    rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_size1 = 2'b00; req_addr1 = 0; req_wdata1 = 0;
    repeat (2) @(negedge CLK);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_l1_ready", req_ready1, 1'b1);
    #2 RST = 1'b1;

    // word round trip
    do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_word_lat", lat, 2);
    chk("st_word_rdata", rd, 32'd0);
    chk("st_word_err", er, 1'b0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("ld_word_lat", lat, 2);
    chk("ld_word_rdata", rd, 32'hDEADBEEF);
    chk("ld_word_err", er, 1'b0);

    // byte/half lanes
    do_req(1'b1, 2'b10, 32'h20, 32'h11223344, rd, er, lat);
    do_req(1'b1, 2'b00, 32'h22, 32'hFFFFFFAA, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("lane_word", rd, 32'h11AA3344);
    do_req(1'b0, 2'b01, 32'h22, 32'h0, rd, er, lat);
    chk("lane_half_hi", rd, 32'h000011AA);
    do_req(1'b0, 2'b01, 32'h20, 32'h0, rd, er, lat);
    chk("lane_half_lo", rd, 32'h00003344);
    do_req(1'b0, 2'b00, 32'h23, 32'h0, rd, er, lat);
    chk("lane_byte3", rd, 32'h00000011);
    do_req(1'b0, 2'b00, 32'h22, 32'h0, rd, er, lat);
    chk("lane_byte2", rd, 32'h000000AA);

    // error cases
    do_req(1'b0, 2'b10, 32'h21, 32'h0, rd, er, lat);
    chk("err_misword_err", er, 1'b1);
    chk("err_misword_rdata", rd, 32'd0);
    do_req(1'b1, 2'b01, 32'h13, 32'h0000FFFF, rd, er, lat);
    chk("err_mishalf_err", er, 1'b1);
    chk("err_mishalf_rdata", rd, 32'd0);
    do_req(1'b0, 2'b11, 32'h0, 32'h0, rd, er, lat);
    chk("err_size_err", er, 1'b1);
    chk("err_size_rdata", rd, 32'd0);
    do_req(1'b0, 2'b10, 32'h1000, 32'h0, rd, er, lat);
    chk("err_range_err", er, 1'b1);
    chk("err_range_rdata", rd, 32'd0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("err_nochange", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'b01, 32'h12, 32'h1234CAFE, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("half_store_hi", rd, 32'hCAFEBEEF);

    // backpressure
    do_req(1'b1, 2'b10, 32'h30, 32'h12345678, rd, er, lat);
    @(negedge CLK);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
    @(negedge CLK);
    req_valid = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_ready", req_ready, 1'b0);
      chk("bp_rdata", rsp_rdata, 32'h11AA3344);
      chk("bp_err", rsp_err, 1'b0);
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_released", rsp_valid, 1'b0);
    do_req(1'b0, 2'b10, 32'h30, 32'h0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'h12345678);

    // reset while waiting on a load
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(negedge CLK);
    req_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", rsp_valid, 1'b0);
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end

    // store accepted just before reset stays committed
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(negedge CLK);
    req_valid = 1'b0;
    #2 RST = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat);
    chk("rst_store_kept", rd, 32'hCAFEF00D);

    // LATENCY=1 instance, back-to-back with rsp_ready tied high
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("l1_idle_ready", req_ready1, 1'b1);
      chk("l1_idle_valid", rsp_valid1, 1'b0);
      req_valid1 = 1'b1;
      req_we1    = l1_we[i];
      req_size1  = 2'b10;
      req_addr1  = l1_addr[i];
      req_wdata1 = l1_wd[i];
      @(negedge CLK);
      chk("l1_rsp_valid", rsp_valid1, 1'b1);
      chk("l1_busy_ready", req_ready1, 1'b0);
      chk("l1_rdata", rsp_rdata1, l1_exp[i]);
      chk("l1_err", rsp_err1, 1'b0);
    end
    req_valid1 = 1'b0;
    @(negedge CLK);
    chk("l1_final_valid", rsp_valid1, 1'b0);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
